activation_stage_ctrl: RTL and testbench

Registered, handshaked replacement for the combinational activation mux on the array's north feedback path. It sits directly downstream of the array's east output and the sigmoid/tanh lane arrays, and directly upstream of the array's north input. On each `start` it selects pass-through, sigmoid or tanh. It then waits for the selected unit's ready edge, latches the full lane bus once and holds it stable, so the array never sees `'z` or a partially-ready bus.

---
 rtl/act_pkg.sv | 20 ++
 rtl/act_lane_reg.sv | 25 ++
 rtl/activation_stage_ctrl.sv | 122 ++++++++++++
 tb/tb_activation_stage_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared encodings for the activation stage: function select, FSM states, error bit positions.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_PASS = 2'd0,
      ACT_SIG  = 2'd1,
      ACT_TANH = 2'd2,
      ACT_RSVD = 2'd3
   } act_func_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRIVE = 2'd2
   } act_state_e;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_ILLEGAL = 1;

endpackage

// File: rtl/act_lane_reg.sv
// Full-width lane bus register with load enable and async active-low clear.
// Latency 1 cycle; no backpressure, holds its value until the next load.
module act_lane_reg #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] bus_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_q <= '0;
      end else if (ld_i) begin
         bus_q <= d_i;
      end
   end

   assign q_o = bus_q;

endmodule

// File: rtl/activation_stage_ctrl.sv
// Registered activation select for the north feedback path: latches east/sigmoid/tanh once per start.
// Latency start->north_valid 2 edges minimum; start outside IDLE is dropped, WAIT aborts after TIMEOUT cycles.
module activation_stage_ctrl
   import act_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int WORD    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            func,
   input  logic [LANES*WORD-1:0] east_o,
   input  logic [LANES*WORD-1:0] sig_o,
   input  logic [LANES*WORD-1:0] tanh_o,
   input  logic                  ready_sig,
   input  logic                  ready_tanh,
   input  logic                  err_clr,
   output logic [LANES*WORD-1:0] north_i,
   output logic                  north_valid,
   output logic                  busy,
   output logic [1:0]            err
);

   localparam int BW = LANES * WORD;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   act_state_e      state_q;
   act_func_e       func_q;
   logic [CW-1:0]   cnt_q;
   logic            sig_prev_q;
   logic            tanh_prev_q;
   logic            north_valid_q;
   logic            busy_q;
   logic [1:0]      err_q;
   logic [1:0]      err_d;
   logic [1:0]      err_set;
   logic            sel_ready;
   logic            sel_prev;
   logic            rise;
   logic            load;
   logic [BW-1:0]   load_dat;

   // Both readies are tracked every cycle so a level already high on WAIT entry never reads as an edge.
   always_comb begin
      sel_ready = (func_q == ACT_TANH) ? ready_tanh  : ready_sig;
      sel_prev  = (func_q == ACT_TANH) ? tanh_prev_q : sig_prev_q;
      rise      = sel_ready & ~sel_prev;
      load      = (state_q == ST_WAIT) && ((func_q == ACT_PASS) || rise);

      case (func_q)
         ACT_SIG:  load_dat = sig_o;
         ACT_TANH: load_dat = tanh_o;
         default:  load_dat = east_o;
      endcase

      err_set              = 2'b00;
      err_set[ERR_ILLEGAL] = (state_q == ST_IDLE) && start && (func == ACT_RSVD);
      err_set[ERR_TIMEOUT] = (state_q == ST_WAIT) && !load && (cnt_q == CNT_LAST);
      err_d                = (err_q & ~{2{err_clr}}) | err_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         func_q        <= ACT_PASS;
         cnt_q         <= '0;
         sig_prev_q    <= 1'b0;
         tanh_prev_q   <= 1'b0;
         north_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 2'b00;
      end else begin
         sig_prev_q    <= ready_sig;
         tanh_prev_q   <= ready_tanh;
         north_valid_q <= 1'b0;
         err_q         <= err_d;
         case (state_q)
            ST_IDLE: begin
               if (start && (func != ACT_RSVD)) begin
                  func_q  <= act_func_e'(func);
                  cnt_q   <= '0;
                  state_q <= ST_WAIT;
                  busy_q  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (load) begin
                  state_q       <= ST_DRIVE;
                  north_valid_q <= 1'b1;
               end else if (err_set[ERR_TIMEOUT]) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   act_lane_reg #(
      .W(BW)
   ) u_north_reg (
      .clk  (clk),
      .rst_n(reset),
      .ld_i (load),
      .d_i  (load_dat),
      .q_o  (north_i)
   );

   assign north_valid = north_valid_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule

// File: tb/tb_activation_stage_ctrl.sv
// Directed plus randomized bench for activation_stage_ctrl against an edge-schedule reference model.
module tb_activation_stage_ctrl;

   localparam int LANES   = 4;
   localparam int WORD    = 32;
   localparam int TIMEOUT = 8;
   localparam int BW      = LANES * WORD;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    func = 2'd0;
   logic [BW-1:0] east_o = '0;
   logic [BW-1:0] sig_o = '0;
   logic [BW-1:0] tanh_o = '0;
   logic          ready_sig = 1'b0;
   logic          ready_tanh = 1'b0;
   logic          err_clr = 1'b0;
   logic [BW-1:0] north_i;
   logic          north_valid;
   logic          busy;
   logic [1:0]    err;

   int            total = 0;
   int            bad = 0;
   logic [BW-1:0] exp_north = '0;
   logic [1:0]    exp_err = 2'b00;
   bit            rq [0:15];
   bit            fixed_en = 1'b0;
   logic [WORD-1:0] fx_east = '0;
   logic [WORD-1:0] fx_sig = '0;
   logic [WORD-1:0] fx_tanh = '0;

   always #5 clk = ~clk;

   activation_stage_ctrl #(
      .LANES  (LANES),
      .WORD   (WORD),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .func       (func),
      .east_o     (east_o),
      .sig_o      (sig_o),
      .tanh_o     (tanh_o),
      .ready_sig  (ready_sig),
      .ready_tanh (ready_tanh),
      .err_clr    (err_clr),
      .north_i    (north_i),
      .north_valid(north_valid),
      .busy       (busy),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input bit vld, input bit bsy);
      chk({tag, ".north_valid"}, BW'(north_valid), BW'(vld));
      chk({tag, ".busy"}, BW'(busy), BW'(bsy));
      chk({tag, ".north_i"}, north_i, exp_north);
      chk({tag, ".err"}, BW'(err), BW'(exp_err));
   endtask

   // Fresh bus contents every cycle; returns the bus the given function would route north.
   task automatic drive_data(input logic [1:0] f, output logic [BW-1:0] sel_bus);
      for (int i = 0; i < LANES; i++) begin
         east_o[i*WORD +: WORD] = fixed_en ? fx_east : WORD'($urandom);
         sig_o[i*WORD +: WORD]  = fixed_en ? fx_sig  : WORD'($urandom);
         tanh_o[i*WORD +: WORD] = fixed_en ? fx_tanh : WORD'($urandom);
      end
      sel_bus = (f == 2'd1) ? sig_o : (f == 2'd2) ? tanh_o : east_o;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // rq[k] is the ready level seen at the k-th edge after start (k=0 is the start edge).
   task automatic run_txn(input logic [1:0] f, input bit junk);
      int            kload;
      int            last;
      bit            tmo;
      logic [BW-1:0] cap;
      kload = 0;
      if (f == 2'd0) kload = 1;
      else if (f != 2'd3) begin
         for (int k = 1; k <= TIMEOUT; k++)
            if (kload == 0 && rq[k] && !rq[k-1]) kload = k;
      end
      tmo  = (f == 2'd1 || f == 2'd2) && (kload == 0);
      last = tmo ? TIMEOUT : kload;

      drive_data(f, cap);
      ready_sig  = rq[0];
      ready_tanh = rq[0];
      start      = 1'b1;
      func       = f;
      err_clr    = 1'b0;
      step();
      start = 1'b0;
      if (f == 2'd3) begin
         exp_err[1] = 1'b1;
         chk_all("illegal", 1'b0, 1'b0);
         return;
      end
      chk_all("accept", 1'b0, 1'b1);

      for (int k = 1; k <= last; k++) begin
         drive_data(f, cap);
         ready_sig  = rq[k];
         ready_tanh = rq[k];
         if (junk) begin
            start = 1'($urandom_range(0, 1));
            func  = 2'($urandom_range(0, 3));
         end
         step();
         start = 1'b0;
         if (k == kload) exp_north = cap;
         if (tmo && k == TIMEOUT) exp_err[0] = 1'b1;
         chk_all(tmo ? "wait_tmo" : "wait", k == kload, !(tmo && k == TIMEOUT));
      end
      if (!tmo) begin
         step();
         chk_all("done", 1'b0, 1'b0);
      end
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      start   = 1'b0;
      step();
      err_clr = 1'b0;
      exp_err = 2'b00;
      chk("err_clr", BW'(err), BW'(exp_err));
   endtask

   initial begin
      #12;
      chk_all("reset", 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Pass-through with a fixed word
      fixed_en = 1'b1;
      fx_east  = 32'h0000_1234;
      fx_sig   = 32'hDEAD_0001;
      fx_tanh  = 32'hBEEF_0002;
      foreach (rq[k]) rq[k] = 1'b0;
      run_txn(2'd0, 1'b0);
      chk("pass_word", BW'(north_i[WORD-1:0]), BW'(32'h0000_1234));

      // Sigmoid: stale-high ready, drop, then a fresh edge on the last allowed WAIT cycle
      fx_sig     = 32'h0000_0800;
      ready_sig  = 1'b1;
      ready_tanh = 1'b1;
      step();
      foreach (rq[k]) rq[k] = 1'b0;
      rq[0] = 1'b1; rq[1] = 1'b1; rq[2] = 1'b1; rq[8] = 1'b1;
      run_txn(2'd1, 1'b0);
      chk("sig_word", BW'(north_i[WORD-1:0]), BW'(32'h0000_0800));

      // Tanh timeout: north_i must keep the sigmoid result
      foreach (rq[k]) rq[k] = 1'b0;
      run_txn(2'd2, 1'b0);
      chk("tmo_err", BW'(err), BW'(2'b01));

      // Extra starts during WAIT are ignored
      clear_err();
      foreach (rq[k]) rq[k] = 1'b0;
      rq[3] = 1'b1;
      run_txn(2'd2, 1'b1);

      // Illegal func, then clear racing a second illegal start
      run_txn(2'd3, 1'b0);
      start   = 1'b1;
      func    = 2'd3;
      err_clr = 1'b1;
      step();
      start   = 1'b0;
      err_clr = 1'b0;
      chk("set_wins", BW'(err), BW'(2'b10));
      clear_err();

      // Asynchronous reset mid-WAIT with err and north_i non-zero
      start = 1'b1;
      func  = 2'd3;
      step();
      exp_err = 2'b10;
      func    = 2'd2;
      ready_sig  = 1'b0;
      ready_tanh = 1'b0;
      step();
      start = 1'b0;
      chk_all("pre_reset", 1'b0, 1'b1);
      step();
      #2 reset = 1'b0;
      #1;
      exp_north = '0;
      exp_err   = 2'b00;
      chk_all("async_reset", 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      step();

      fixed_en = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) clear_err();
         foreach (rq[k]) rq[k] = ($urandom_range(0, 3) == 0);
         run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
